led_scan_mux: RTL and testbench
===============================

LED_SCAN_MUX -- requirements
Module: led_scan_mux

Interface
REQ-001 SHALL have parameter F_CLK, default 50000000: input clock frequency in Hz.
REQ-002 SHALL have parameter F_SCAN, default 1000: digit-step rate in Hz, and F_CLK/F_SCAN SHALL be >= 4.
REQ-003 SHALL have parameter N_DIG, default 8: digit count, legal range 1..16, not required to be a power of 2.
REQ-004 SHALL have parameter CS_ACTIVE_LOW, default 0: 1 inverts every cs bit.
REQ-005 SHALL have port clk, input, 1 bit: single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port wr_en, input, 1 bit: digit register write strobe.
REQ-008 SHALL have port wr_addr, input, AW = max(1, clog2(N_DIG)) bits: digit index; writes with wr_addr >= N_DIG are ignored.
REQ-009 SHALL have port wr_data, input, 5 bits: bit 4 = dot, bits 3:0 = hex value.
REQ-010 SHALL have port blank_mask, input, N_DIG bits: 1 = digit forced dark.
REQ-011 SHALL have port cs, output, N_DIG bits: one-hot digit select.
REQ-012 SHALL have port o_dig_sel, output, 8 bits: bit 7 = dp, bits 6:0 = g..a, 1 = lit.
REQ-013 SHALL have port scan_idx, output, AW bits: index of the digit currently driven.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed scan frame.

Function
REQ-015 SHALL generate an internal one-cycle tick every F_CLK/F_SCAN clk cycles from a counter; there SHALL be no derived or gated clocks.
REQ-016 SHALL advance the pointer on each tick: 0,1,...,N_DIG-1, then back to 0.
REQ-017 SHALL assert frame_done for exactly the tick cycle on which the pointer wraps from N_DIG-1 to 0; with N_DIG=1 it SHALL pulse on every tick.
REQ-018 SHALL register cs, o_dig_sel and scan_idx with 1-cycle latency: a pointer change at edge t appears on the outputs at edge t+1.
REQ-019 SHALL hold N_DIG 5-bit digit registers; a write accepted on edge t SHALL be visible on o_dig_sel at edge t+1 when that digit is selected.
REQ-020 A write and a tick in the same cycle SHALL both take effect; a write to the newly selected digit SHALL show the new value at edge t+2 at the latest.
REQ-021 SHALL decode hex 0-F to standard 7-segment patterns (0 = 0x3F, 1 = 0x06, ..., F = 0x71), with the dp bit equal to the stored dot.
REQ-022 For a digit whose blank_mask bit is 1, cs SHALL be all-inactive and o_dig_sel SHALL be 0 during that digit's slot; blank_mask SHALL be sampled every cycle.
REQ-023 cs SHALL never have more than one active bit.

Reset
REQ-024 On rst_n low, asynchronously: all digit registers = 0, pointer = 0, tick counter = 0, cs = all-inactive, o_dig_sel = 0, scan_idx = 0, frame_done = 0.
REQ-025 The first tick after reset release SHALL occur F_CLK/F_SCAN cycles later; until then the outputs SHALL show digit 0 from edge 1 after release.
REQ-026 Reset asserted mid-frame SHALL abort the scan with no residual pulse on frame_done.

Configuration
REQ-027 With macro LED_SCAN_DEADTIME_EN defined, cs SHALL be all-inactive and o_dig_sel SHALL be 0 for the first 2 cycles of every digit slot (anti-ghosting).
REQ-028 Without LED_SCAN_DEADTIME_EN, the new digit SHALL be driven immediately per REQ-018.

Structure
REQ-029 Package led_pkg SHALL hold digit_t (packed struct: dot, hex[3:0]), seg_t (8-bit) and the constant 16-entry hex-to-seg table SEG_LUT.
REQ-030 Sub-module led_tick_gen SHALL contain the parametrised divider (parameter DIV) and output the one-cycle tick.

Verification
REQ-031 With F_CLK=100, F_SCAN=10, N_DIG=8 and writes 0..7 to digits 0..7: cs walks 0x01 to 0x80 with one step per 10 cycles, and o_dig_sel shows 0x3F, 0x06, 0x5B, ..., 0x07.
REQ-032 With N_DIG=5: scan_idx follows 0,1,2,3,4,0; frame_done pulses once per 50 cycles, on the 4-to-0 wrap.
REQ-033 Writing 0x1A to digit 3 while digit 3 is displayed: o_dig_sel = 0xF7 one cycle later; a write with wr_addr=7 when N_DIG=5 leaves all outputs unchanged.
REQ-034 With blank_mask=0x04: during slot 2, cs = 0 and o_dig_sel = 0; all other slots are normal.
REQ-035 With CS_ACTIVE_LOW=1 and LED_SCAN_DEADTIME_EN defined: cs = 0xFF for 2 cycles after each tick, then one bit goes low.
REQ-036 Asserting rst_n low mid-slot 6: all outputs reach their reset values immediately, and the scan restarts from digit 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and the hex-to-seven-segment table for the LED scan multiplexer.
package led_pkg;

    // One stored digit: decimal point plus a 4-bit hex value
    typedef struct packed {
        logic       dot;
        logic [3:0] hex;
    } digit_t;

    // Segment byte: bit 7 = dp, bits 6:0 = g..a, 1 = lit
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_LUT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    function automatic seg_t seg_decode(input digit_t d);
        seg_t s;
        s    = SEG_LUT[d.hex];
        s[7] = d.dot;
        return s;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clk cycles.
module led_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 and wrap; the tick is the terminal-count cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_scan_mux.sv
// Multiplexed seven-segment LED scanner: N_DIG digit registers, one digit
// driven per scan slot, registered cs / segment / index outputs.
// Optional macro LED_SCAN_DEADTIME_EN blanks the first 2 cycles of every
// digit slot to suppress ghosting.
module led_scan_mux
    import led_pkg::*;
#(
    parameter  int F_CLK         = 50000000,
    parameter  int F_SCAN        = 1000,
    parameter  int N_DIG         = 8,
    parameter  int CS_ACTIVE_LOW = 0,
    localparam int AW            = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [4:0]       wr_data,
    input  logic [N_DIG-1:0] blank_mask,
    output logic [N_DIG-1:0] cs,
    output logic [7:0]       o_dig_sel,
    output logic [AW-1:0]    scan_idx,
    output logic             frame_done
);

    localparam int               DIV      = F_CLK / F_SCAN;
    localparam logic [AW-1:0]    LAST_IDX = AW'(N_DIG - 1);
    localparam logic [N_DIG-1:0] CS_IDLE  = {N_DIG{CS_ACTIVE_LOW != 0}};

    logic             tick;
    logic [AW-1:0]    ptr;
    digit_t           digits [N_DIG];
    logic             wr_ok;
    logic             dark;
    logic [N_DIG-1:0] sel_onehot;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign wr_ok      = (32'(wr_addr) < 32'(N_DIG));
    assign frame_done = tick && (ptr == LAST_IDX);

    // Scan pointer steps once per tick and wraps after the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (tick) begin
            ptr <= (ptr == LAST_IDX) ? '0 : ptr + AW'(1);
        end
    end

    // Digit register file; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= '{default: '0};
        end else if (wr_en && wr_ok) begin
            digits[wr_addr] <= digit_t'(wr_data);
        end
    end

`ifdef LED_SCAN_DEADTIME_EN
    logic [1:0] age;

    // Cycles since the pointer last moved, saturating at 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (tick) begin
            age <= '0;
        end else if (age != 2'd2) begin
            age <= age + 2'd1;
        end
    end

    assign dark = blank_mask[ptr] || (age != 2'd2);
`else
    assign dark = blank_mask[ptr];
`endif

    // One-hot decode of the pointer
    always_comb begin
        sel_onehot      = '0;
        sel_onehot[ptr] = 1'b1;
    end

    // Output stage: registered one cycle behind the pointer and digit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs        <= CS_IDLE;
            o_dig_sel <= '0;
            scan_idx  <= '0;
        end else begin
            scan_idx <= ptr;
            if (dark) begin
                cs        <= CS_IDLE;
                o_dig_sel <= '0;
            end else begin
                cs        <= sel_onehot ^ CS_IDLE;
                o_dig_sel <= seg_decode(digits[ptr]);
            end
        end
    end

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench for led_scan_mux (N_DIG=5, 10 clk cycles per digit slot).
`timescale 1ns/1ps
module tb_led_scan_mux;

    localparam int F_CLK         = 100;
    localparam int F_SCAN        = 10;
    localparam int N_DIG         = 5;
    localparam int CS_ACTIVE_LOW = 0;
    localparam int DIV           = F_CLK / F_SCAN;
    localparam int AW            = 3;
    localparam logic [N_DIG-1:0] IDLE = {N_DIG{CS_ACTIVE_LOW != 0}};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [4:0]       wr_data = '0;
    logic [N_DIG-1:0] blank_mask = '0;
    logic [N_DIG-1:0] cs;
    logic [7:0]       o_dig_sel;
    logic [AW-1:0]    scan_idx;
    logic             frame_done;

    led_scan_mux #(
        .F_CLK         (F_CLK),
        .F_SCAN        (F_SCAN),
        .N_DIG         (N_DIG),
        .CS_ACTIVE_LOW (CS_ACTIVE_LOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .blank_mask (blank_mask),
        .cs         (cs),
        .o_dig_sel  (o_dig_sel),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_DIG-1:0] cs;
        logic [7:0]       seg;
        logic [AW-1:0]    idx;
        logic             fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: clock edges since reset release and the digit memory
    int         k = 0;
    logic [4:0] mem [N_DIG];
    logic [7:0] seg_ref [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    int   p;
    bit   dk;
    exp_t e;
    exp_t m_e;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Reference model: after edge k the pointer is (k/DIV) mod N_DIG; outputs
    // show the pointer and memory as they stood before the edge.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            k = 0;
            foreach (mem[i]) mem[i] = 5'h00;
            exp_q.delete();
            e.cs  = IDLE;
            e.seg = 8'h00;
            e.idx = '0;
            e.fd  = 1'b0;
            exp_q.push_back(e);
        end else begin
            p  = (k / DIV) % N_DIG;
            dk = blank_mask[p];
`ifdef LED_SCAN_DEADTIME_EN
            dk = dk || ((k % DIV) < 2);
`endif
            e.idx = p[AW-1:0];
            e.cs  = dk ? IDLE : ((N_DIG'(1) << p) ^ IDLE);
            e.seg = dk ? 8'h00 : {mem[p][4], seg_ref[mem[p][3:0]][6:0]};
            if (wr_en && (int'(wr_addr) < N_DIG)) mem[wr_addr] = wr_data;
            k++;
            e.fd = ((k % DIV) == DIV - 1) && (((k / DIV) % N_DIG) == N_DIG - 1);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            check("cs", 32'(cs), 32'(m_e.cs));
            check("o_dig_sel", 32'(o_dig_sel), 32'(m_e.seg));
            check("scan_idx", 32'(scan_idx), 32'(m_e.idx));
            check("frame_done", 32'(frame_done), 32'(m_e.fd));
            check("cs_onehot", 32'($countones(cs ^ IDLE) <= 1), 1);
        end
    end

    task automatic wait_idx(input int idx, input string name);
        int n;
        n = 0;
        while ((int'(scan_idx) != idx) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(scan_idx), idx);
    endtask

    task automatic random_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = 5'($urandom);
            if ($urandom_range(0, 9) == 0) blank_mask = N_DIG'($urandom);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Digits 0..4 hold their own index
        for (int i = 0; i < N_DIG; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = i[AW-1:0];
            wr_data = i[4:0];
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2 * DIV * N_DIG) @(negedge clk);

        // Out-of-range addresses must not disturb anything
        for (int a = N_DIG; a < 8; a++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = a[AW-1:0];
            wr_data = 5'h1F;
        end
        @(negedge clk);
        wr_en = 1'b0;

        // 0x1A into digit 3 while it is on display
        wait_idx(3, "wait_slot3");
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 5'h1A;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (DIV * N_DIG) @(negedge clk);

        // Slot 2 blanked
        blank_mask = 5'b00100;
        repeat (2 * DIV * N_DIG) @(negedge clk);
        blank_mask = '0;

        random_cycles(1500);

        // Reset in the middle of the last slot
        wr_en = 1'b0;
        wait_idx(4, "wait_slot4");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV * N_DIG + 5) @(negedge clk);

        random_cycles(500);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
